receiver: RTL and testbench
===========================

# receiver

UART receive engine; the far end of the serial line driven by `transmitter`. It samples `rx_i` with the shared 16x oversampling baud strobe and deserialises 5–8 data bits, LSB first. It checks the optional parity bit and 1 or 2 stop bits, then presents each received word with error flags. It also detects the configuration request, a line held low for a fixed number of clocks, and signals it to the controller as `config_req_slv_o`.

## Interface
- `CFG_REQ_CYCLES`, default 100000: consecutive low-line clocks that constitute a configuration request. Equal to the transmitter's 1 ms count.
- `clk_i  in  1`  system clock.
- `rst_i  in  1`  reset, asynchronous, active-high.
- `enable_i  in  1`  permits detection of new start bits.
- `ov_baud_rt_i  in  1`  one-clock strobe, 16 per bit period.
- `rx_i  in  1`  serial line, asynchronous, idle high.
- `data_width_i  in  2`  00=5, 01=6, 10=7, 11=8 bits.
- `parity_mode_i  in  2`  bit1=1 means no parity; bit0 selects 0=even, 1=odd.
- `stop_bits_number_i  in  2`  01 means 2 stop bits; any other value means 1.
- `data_rx_o  out  8`  last received word, right-aligned, upper bits zero.
- `rx_done_o  out  1`  one-clock pulse when a frame completes.
- `parity_err_o  out  1`  parity error for the last frame.
- `frame_err_o  out  1`  a stop bit sampled low in the last frame.
- `config_req_slv_o  out  1`  one-clock pulse when a configuration request is detected.
- `rx_idle_o  out  1`  high while in RX_IDLE.

## Operation
- `rx_i` passes through a 2-FF synchroniser. All logic uses the synchronised value `rx_s`.
- Reset values:
  - `data_rx_o`=0, `rx_done_o`=0, `parity_err_o`=0, `frame_err_o`=0, `config_req_slv_o`=0.
  - `rx_idle_o`=1.
  - State RX_IDLE; all counters 0; synchroniser flops 1.
- A 4-bit tick counter advances on `ov_baud_rt_i` and is cleared on every state change.
- **RX_IDLE**: if `enable_i` and `rx_s`=0, clear the tick counter and go to RX_START.
- **RX_START**: at tick 7 (mid start bit):
  - `rx_s`=1 means a false start; return to RX_IDLE.
  - Otherwise clear the counter and go to RX_DATA.
- **RX_DATA**: at tick 15 (bit centre), shift `rx_s` into the MSB of an 8-bit shift register and increment the bit count.
  - After `data_width_i`+5 bits, go to RX_PARITY if parity is enabled, else RX_STOP.
- **RX_PARITY**: at tick 15, compute the error as XOR of the received data bits, the parity bit, and `parity_mode_i[0]`. Latch this internally, then go to RX_STOP.
- **RX_STOP**: at tick 15, sample the stop bit; a 0 sets the internal frame error.
  - With 2 stop bits, the first sample stays in RX_STOP for one more bit.
  - On the final stop sample, the same edge does all of the following:
    - loads `data_rx_o` with the shift register shifted right by 8−width;
    - loads `parity_err_o` (0 when parity is disabled) and `frame_err_o`;
    - pulses `rx_done_o`;
    - returns to RX_IDLE.
- **RX_CFG_REQ**: wait for `rx_s`=1, then return to RX_IDLE. No `rx_done_o` is issued.
- **Configuration detector** (runs independently of state and `enable_i`):
  - A low counter increments each clock `rx_s`=0 and clears when `rx_s`=1.
  - It saturates at `CFG_REQ_CYCLES`.
  - On the clock it reaches `CFG_REQ_CYCLES`, `config_req_slv_o` pulses once. The FSM aborts any frame in progress without updating outputs and enters RX_CFG_REQ.
- `enable_i` deasserted mid-frame has no effect; the frame completes.
- Error flags hold until the next completed frame and are never sticky across frames.

## Timing
- `rx_i` to `rx_s`: 2 clocks.
- Start detection to start validation: 8 ticks. Each data, parity and stop bit then takes 16 ticks.
- `rx_done_o` fires 8 ticks into the last stop bit, so the line is still high. This allows immediate resynchronisation to the next start edge.
- `rx_done_o`, `config_req_slv_o`: single-cycle, registered.
- `rx_idle_o`: combinational from state.
- The configuration pulse occurs `CFG_REQ_CYCLES`+2 clocks after `rx_i` falls (including the synchroniser).
- Simultaneous cases:
  - If the configuration threshold and the final stop sample occur in the same cycle, the configuration request wins and no `rx_done_o` is issued.
  - A tick on the cycle of a state change is consumed by the counter clear.
- Asynchronous reset mid-frame returns all outputs and state to reset values immediately. The next frame is received only after a fresh falling edge.

## Test plan
- 8N1, frame 0xA5 at 16 ticks/bit -> one `rx_done_o` pulse; `data_rx_o`=0xA5; both error flags 0.
- 7-bit, even parity, 2 stop bits; send 0x35 with a wrong parity bit -> `data_rx_o`=0x35, `parity_err_o`=1. The next good frame 0x12 clears it.
- Low glitch of 4 ticks on an idle line -> no `rx_done_o`; `rx_idle_o` returns to 1 after tick 7.
- 5N1, frame 0x1F with the stop bit driven 0 -> `data_rx_o`=0x1F, `frame_err_o`=1.
- Line low for `CFG_REQ_CYCLES`+10 clocks, then high -> exactly one `config_req_slv_o` pulse, no `rx_done_o`, return to RX_IDLE after the line rises.
- `rst_i` asserted during data bit 3 of 0xC3 -> all outputs at reset values immediately. A following 0x3C frame is received correctly.

Source files
------------

// File: rtl/receiver.sv
// UART receive engine: 16x oversampled deserialiser for 5-8 data bits with optional parity,
// 1 or 2 stop bits, and detection of a long-low configuration request.
module receiver #(
  parameter int unsigned CFG_REQ_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic [1:0] stop_bits_number_i,
  output logic [7:0] data_rx_o,
  output logic       rx_done_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       config_req_slv_o,
  output logic       rx_idle_o
);

  localparam int unsigned CntW = $clog2(CFG_REQ_CYCLES + 1);
  localparam logic [CntW-1:0] CfgMax  = CntW'(CFG_REQ_CYCLES);
  localparam logic [CntW-1:0] CfgLast = CntW'(CFG_REQ_CYCLES - 1);

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxCfgReq} state_e;

  state_e          state_q;
  logic            rx_meta_q;
  logic            rx_s;
  logic [3:0]      tick_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            par_err_q;
  logic            frm_err_q;
  logic            stop_cnt_q;
  logic [CntW-1:0] low_cnt_q;

  logic cfg_hit;
  logic tick_mid;
  logic tick_end;
  logic bit_last;
  logic parity_en;
  logic two_stop;

  assign cfg_hit   = ~rx_s && (low_cnt_q == CfgLast);
  assign tick_mid  = ov_baud_rt_i && (tick_q == 4'd7);
  assign tick_end  = ov_baud_rt_i && (tick_q == 4'd15);
  assign bit_last  = bit_cnt_q == ({1'b0, data_width_i} + 3'd4);
  assign parity_en = ~parity_mode_i[1];
  assign two_stop  = stop_bits_number_i == 2'b01;
  assign rx_idle_o = state_q == RxIdle;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s      <= rx_meta_q;
    end
  end

  // Low-line run length; saturates so the request pulses once per low period.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      low_cnt_q <= '0;
    end else if (rx_s) begin
      low_cnt_q <= '0;
    end else if (low_cnt_q != CfgMax) begin
      low_cnt_q <= low_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= RxIdle;
      tick_q           <= 4'd0;
      bit_cnt_q        <= 3'd0;
      shift_q          <= 8'd0;
      par_err_q        <= 1'b0;
      frm_err_q        <= 1'b0;
      stop_cnt_q       <= 1'b0;
      data_rx_o        <= 8'd0;
      rx_done_o        <= 1'b0;
      parity_err_o     <= 1'b0;
      frame_err_o      <= 1'b0;
      config_req_slv_o <= 1'b0;
    end else begin
      rx_done_o        <= 1'b0;
      config_req_slv_o <= 1'b0;
      if (ov_baud_rt_i) tick_q <= tick_q + 4'd1;
      if (cfg_hit) begin
        config_req_slv_o <= 1'b1;
        state_q          <= RxCfgReq;
        tick_q           <= 4'd0;
      end else begin
        unique case (state_q)
          RxIdle: begin
            if (enable_i && !rx_s) begin
              state_q <= RxStart;
              tick_q  <= 4'd0;
            end
          end
          RxStart: begin
            if (tick_mid) begin
              tick_q <= 4'd0;
              if (rx_s) begin
                state_q <= RxIdle;
              end else begin
                state_q    <= RxData;
                bit_cnt_q  <= 3'd0;
                shift_q    <= 8'd0;
                par_err_q  <= 1'b0;
                frm_err_q  <= 1'b0;
                stop_cnt_q <= 1'b0;
              end
            end
          end
          RxData: begin
            if (tick_end) begin
              shift_q   <= {rx_s, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_last) begin
                tick_q  <= 4'd0;
                state_q <= parity_en ? RxParity : RxStop;
              end
            end
          end
          RxParity: begin
            if (tick_end) begin
              // Unused low bits of shift_q are zero, so the full XOR covers only data.
              par_err_q <= ^shift_q ^ rx_s ^ parity_mode_i[0];
              tick_q    <= 4'd0;
              state_q   <= RxStop;
            end
          end
          RxStop: begin
            if (tick_end) begin
              if (!rx_s) frm_err_q <= 1'b1;
              if (two_stop && !stop_cnt_q) begin
                stop_cnt_q <= 1'b1;
              end else begin
                data_rx_o    <= shift_q >> (2'd3 - data_width_i);
                parity_err_o <= parity_en & par_err_q;
                frame_err_o  <= frm_err_q | ~rx_s;
                rx_done_o    <= 1'b1;
                tick_q       <= 4'd0;
                state_q      <= RxIdle;
              end
            end
          end
          RxCfgReq: begin
            if (rx_s) begin
              state_q <= RxIdle;
              tick_q  <= 4'd0;
            end
          end
          default: state_q <= RxIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for the UART receiver: one bit period is 16 strobes of 2 clocks each.
module tb_receiver;

  localparam int unsigned Cfg = 400;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       ov_baud;
  logic       rx;
  logic [1:0] dw;
  logic [1:0] pm;
  logic [1:0] sb;
  logic [7:0] data_rx;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       cfg_req;
  logic       rx_idle;

  int checks;
  int errors;
  int done_cnt;
  int cfg_cnt;

  receiver #(.CFG_REQ_CYCLES(Cfg)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .enable_i           (enable),
    .ov_baud_rt_i       (ov_baud),
    .rx_i               (rx),
    .data_width_i       (dw),
    .parity_mode_i      (pm),
    .stop_bits_number_i (sb),
    .data_rx_o          (data_rx),
    .rx_done_o          (rx_done),
    .parity_err_o       (parity_err),
    .frame_err_o        (frame_err),
    .config_req_slv_o   (cfg_req),
    .rx_idle_o          (rx_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ov_baud = 1'b0;
    forever begin
      @(negedge clk);
      ov_baud = ~ov_baud;
    end
  end

  always @(negedge clk) begin
    if (rx_done) done_cnt++;
    if (cfg_req) cfg_cnt++;
  end

  task automatic bit_time(input logic v);
    rx = v;
    repeat (32) @(negedge clk);
  endtask

  // par: 0 none, 1 even, 2 odd. The first stop bit is held for 24 clocks, enough to cover its
  // centre sample, then the line rises so a low stop does not look like a new start.
  task automatic send_frame(input logic [7:0] d, input int w, input int par, input logic bad,
                            input int ns, input logic stop0);
    logic p;
    p = 1'b0;
    bit_time(1'b0);
    for (int i = 0; i < w; i++) begin
      bit_time(d[i]);
      p = p ^ d[i];
    end
    if (par == 1) bit_time(p ^ bad);
    else if (par == 2) bit_time(~p ^ bad);
    rx = stop0;
    repeat (24) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    if (ns == 2) bit_time(1'b1);
    bit_time(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; enable = 1'b1; dw = 2'b11; pm = 2'b10; sb = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (data_rx !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_rx); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", rx_done); end
    checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_errs got %b%b exp 00", parity_err, frame_err); end
    checks++; if (cfg_req !== 1'b0) begin errors++; $display("FAIL reset_cfg got %b exp 0", cfg_req); end
    checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", rx_idle); end
    rst = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_8n1();
    int d0;
    dw = 2'b11; pm = 2'b10; sb = 2'b00;
    d0 = done_cnt;
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL 8n1_done got %0d exp %0d", done_cnt - d0, 1); end
    checks++; if (data_rx !== 8'hA5) begin errors++; $display("FAIL 8n1_data got %h exp a5", data_rx); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL 8n1_perr got %b exp 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL 8n1_ferr got %b exp 0", frame_err); end
  endtask

  task automatic test_parity();
    int d0;
    dw = 2'b10; pm = 2'b00; sb = 2'b01;
    d0 = done_cnt;
    send_frame(8'h35, 7, 1, 1'b1, 2, 1'b1);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL par_done got %0d exp %0d", done_cnt - d0, 1); end
    checks++; if (data_rx !== 8'h35) begin errors++; $display("FAIL par_data got %h exp 35", data_rx); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_err_set got %b exp 1", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_ferr got %b exp 0", frame_err); end
    send_frame(8'h12, 7, 1, 1'b0, 2, 1'b1);
    checks++; if (data_rx !== 8'h12) begin errors++; $display("FAIL par_good_data got %h exp 12", data_rx); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_err_clr got %b exp 0", parity_err); end
    checks++; if (done_cnt !== d0 + 2) begin errors++; $display("FAIL par_done2 got %0d exp %0d", done_cnt - d0, 2); end
  endtask

  task automatic test_glitch();
    int d0;
    dw = 2'b11; pm = 2'b10; sb = 2'b00;
    d0 = done_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (rx_idle !== 1'b0) begin errors++; $display("FAIL glitch_start got %b exp 0", rx_idle); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_idle !== 1'b0) begin errors++; $display("FAIL glitch_wait got %b exp 0", rx_idle); end
    repeat (20) @(negedge clk);
    checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL glitch_idle got %b exp 1", rx_idle); end
    repeat (64) @(negedge clk);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL glitch_done got %0d exp 0", done_cnt - d0); end
  endtask

  task automatic test_frame_err();
    int d0;
    dw = 2'b00; pm = 2'b10; sb = 2'b00;
    d0 = done_cnt;
    send_frame(8'h1F, 5, 0, 1'b0, 1, 1'b0);
    checks++; if (data_rx !== 8'h1F) begin errors++; $display("FAIL ferr_data got %h exp 1f", data_rx); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got %b exp 1", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL ferr_perr got %b exp 0", parity_err); end
    send_frame(8'h0A, 5, 0, 1'b0, 1, 1'b1);
    checks++; if (data_rx !== 8'h0A) begin errors++; $display("FAIL ferr_next_data got %h exp 0a", data_rx); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr got %b exp 0", frame_err); end
    checks++; if (done_cnt !== d0 + 2) begin errors++; $display("FAIL ferr_done got %0d exp %0d", done_cnt - d0, 2); end
  endtask

  task automatic test_cfg_req();
    int d0;
    int c0;
    int seen;
    enable = 1'b0;
    d0 = done_cnt;
    c0 = cfg_cnt;
    seen = 0;
    rx = 1'b0;
    for (int i = 1; i <= int'(Cfg) + 10; i++) begin
      @(negedge clk);
      if (cfg_req && seen == 0) seen = i;
    end
    checks++; if (seen !== int'(Cfg) + 2) begin errors++; $display("FAIL cfg_latency got %0d exp %0d", seen, Cfg + 2); end
    checks++; if (rx_idle !== 1'b0) begin errors++; $display("FAIL cfg_state got %b exp 0", rx_idle); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL cfg_return got %b exp 1", rx_idle); end
    checks++; if (cfg_cnt !== c0 + 1) begin errors++; $display("FAIL cfg_pulses got %0d exp 1", cfg_cnt - c0); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL cfg_done got %0d exp 0", done_cnt - d0); end
    enable = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int d0;
    dw = 2'b11; pm = 2'b10; sb = 2'b00;
    d0 = done_cnt;
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    bit_time(1'b0);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (data_rx !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp 00", data_rx); end
    checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL rst_mid_idle got %b exp 1", rx_idle); end
    checks++; if (rx_done !== 1'b0 || cfg_req !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got %b%b%b%b exp 0000", rx_done, cfg_req, parity_err, frame_err); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    bit_time(1'b1);
    bit_time(1'b1);
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1);
    checks++; if (data_rx !== 8'h3C) begin errors++; $display("FAIL rst_next_data got %h exp 3c", data_rx); end
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL rst_next_done got %0d exp 1", done_cnt - d0); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_next_ferr got %b exp 0", frame_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    done_cnt = 0;
    cfg_cnt = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_frame_err();
    test_cfg_req();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
